led7seg_scan: RTL and testbench



---
 rtl/led7seg_pkg.sv | 37 +++
 rtl/led7seg_decoder.sv | 25 ++
 rtl/led7seg_scan.sv | 136 +++++++++++++
 tb/tb_led7seg_scan.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/led7seg_pkg.sv
// Shared definitions for the multiplexed 7-segment driver: hex decode table,
// the all-segments-off pattern, and a width helper for counters/indices.
package led7seg_pkg;

  // Active-high pattern with every segment and dp dark.
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Active-high a..g pattern for one hex nibble; bit 0 = a, bit 6 = g.
  function automatic logic [6:0] hex2seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led7seg_decoder.sv
// Combinational nibble/dp/blank/suppress -> 8-bit segment drive, zero latency.
// blank darkens everything; suppress darkens a..g but keeps dp.
module led7seg_decoder
  import led7seg_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  input  logic       suppress,
  output logic [7:0] led
);

  logic [7:0] lit;

  always_comb begin
    lit = SEG_OFF;
    if (!blank) begin
      lit = {dp, suppress ? 7'h00 : hex2seg(nibble)};
    end
    led = (ACTIVE_LOW != 0) ? ~lit : lit;
  end

endmodule

// File: rtl/led7seg_scan.sv
// Time-multiplexed 7-seg scanner with frame-boundary double buffering; SA/LED lag idx by one clk.
// No backpressure: load is a strobe, last one before a boundary wins. LED7SEG_LZS_EN adds leading-zero suppression.
module led7seg_scan
  import led7seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  output logic [7:0]              LED,
  output logic [NUM_DIGITS-1:0]   SA,
  output logic                    frame_tick
);

  localparam int IW = clog2_min1(NUM_DIGITS);
  localparam int PW = clog2_min1(REFRESH_DIV);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] SA_OFF = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [7:0] LED_OFF = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           idx;
  logic                    tick;
  logic                    boundary;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] shadow_digits, active_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp, active_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank, active_blank;
  logic [3:0]              cur_nibble;
  logic                    suppress;
  logic [7:0]              led_next;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic [NUM_DIGITS-1:0]   sa_next;

  assign tick     = (prescaler == PRE_LAST);
  assign boundary = tick && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (tick) begin
      prescaler <= '0;
      idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // A load landing on the boundary itself goes straight to active so it is not held a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= 1'b0;
      shadow_digits <= '0;
      shadow_dp     <= '0;
      shadow_blank  <= '1;
      active_digits <= '0;
      active_dp     <= '0;
      active_blank  <= '1;
    end else begin
      if (load) begin
        shadow_digits <= digits;
        shadow_dp     <= dp;
        shadow_blank  <= blank;
      end
      if (boundary) begin
        if (load) begin
          active_digits <= digits;
          active_dp     <= dp;
          active_blank  <= blank;
        end else if (pending) begin
          active_digits <= shadow_digits;
          active_dp     <= shadow_dp;
          active_blank  <= shadow_blank;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  assign cur_nibble = active_digits[4*int'(idx) +: 4];

`ifdef LED7SEG_LZS_EN
  logic [NUM_DIGITS-1:0] zero_above;

  // zero_above[i]: nibble i and every higher nibble are zero; digit 0 never qualifies.
  always_comb begin
    logic run;
    run        = 1'b1;
    zero_above = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run           = run && (active_digits[4*i +: 4] == 4'h0);
      zero_above[i] = run;
    end
  end

  assign suppress = zero_above[idx];
`else
  assign suppress = 1'b0;
`endif

  led7seg_decoder #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_decoder (
    .nibble   (cur_nibble),
    .dp       (active_dp[idx]),
    .blank    (active_blank[idx]),
    .suppress (suppress),
    .led      (led_next)
  );

  assign sel_onehot = NUM_DIGITS'(1) << idx;
  assign sa_next    = (ACTIVE_LOW != 0) ? ~sel_onehot : sel_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SA         <= SA_OFF;
      LED        <= LED_OFF;
      frame_tick <= 1'b0;
    end else begin
      SA         <= sa_next;
      LED        <= led_next;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_led7seg_scan.sv
// Bench for led7seg_scan: directed display cases plus random loads, checked against a frame-arithmetic model.
module tb_led7seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic        load = 1'b0;
  logic [7:0]  led4, led1;
  logic [3:0]  sa4, sa1;
  logic        ft4, ft1;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int t = 0;

  typedef struct {
    int          t;
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  bl;
  } load_rec_t;

  load_rec_t load_q[$];

  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  led7seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .blank(blank), .load(load),
    .LED(led4), .SA(sa4), .frame_tick(ft4)
  );

  led7seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(1), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .blank(blank), .load(load),
    .LED(led1), .SA(sa1), .frame_tick(ft1)
  );

  // Expected outputs after clock edge number t since reset release. The shown
  // value is the last load at or before the latest frame-boundary edge.
  function automatic void model(input int div, output logic [3:0] sa,
                                output logic [7:0] led, output logic ft);
    int          tp, idx, bnd;
    logic [15:0] d;
    logic [3:0]  dpv, blv;
    logic [7:0]  on;
    sa  = 4'hF;
    led = 8'hFF;
    ft  = 1'b0;
    if (t == 0) return;
    tp  = t - 1;
    idx = (tp / div) % 4;
    bnd = (tp / (div * 4)) * (div * 4);
    d   = 16'h0;
    dpv = 4'h0;
    blv = 4'hF;
    foreach (load_q[k]) begin
      if (load_q[k].t <= bnd) begin
        d   = load_q[k].d;
        dpv = load_q[k].dp;
        blv = load_q[k].bl;
      end
    end
    sa = ~(4'b0001 << idx);
    on = 8'h00;
    if (!blv[idx]) begin
      on = {dpv[idx], SEG[d[4*idx +: 4]]};
`ifdef LED7SEG_LZS_EN
      if (idx >= 1 && (d >> (4 * idx)) == 16'h0) on[6:0] = 7'h00;
`endif
    end
    led = ~on;
    ft  = ((t % (div * 4)) == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s at t=%0d: observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_now();
    logic [3:0] esa;
    logic [7:0] eled;
    logic       eft;
    model(4, esa, eled, eft);
    chk("sa_div4", 32'(sa4), 32'(esa));
    chk("led_div4", 32'(led4), 32'(eled));
    chk("ft_div4", 32'(ft4), 32'(eft));
    model(1, esa, eled, eft);
    chk("sa_div1", 32'(sa1), 32'(esa));
    chk("led_div1", 32'(led1), 32'(eled));
    chk("ft_div1", 32'(ft1), 32'(eft));
    if (t >= 1) chk("onehot_div1", 32'($countones(~sa1)), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      t++;
      if (load) load_q.push_back(load_rec_t'{t, digits, dp, blank});
    end
    @(negedge clk);
    check_now();
  endtask

  task automatic goto(input int target);
    int guard;
    guard = 0;
    while (t < target && guard < 2000) begin
      step();
      guard++;
    end
    chk("goto_reached", 32'(t), 32'(target));
  endtask

  function automatic int next_frame();
    return ((t / 16) + 1) * 16;
  endfunction

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    digits = d;
    dp     = p;
    blank  = b;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  initial begin
    int b;
    logic [15:0] mask;

    repeat (3) @(negedge clk);
    chk("reset_sa", 32'(sa4), 32'h0000000F);
    chk("reset_led", 32'(led4), 32'h000000FF);
    chk("reset_ft", 32'(ft4), 32'h0);
    rst_n = 1'b1;
    check_now();
    repeat (20) step();

    // 1234, each digit checked against its hand-decoded pattern.
    do_load(16'h1234, 4'h0, 4'h0);
    b = next_frame();
    goto(b + 1);  chk("d0_1234_sa", 32'(sa4), 32'hE); chk("d0_1234_led", 32'(led4), 32'h99);
    goto(b + 5);  chk("d1_1234_sa", 32'(sa4), 32'hD); chk("d1_1234_led", 32'(led4), 32'hB0);
    goto(b + 9);  chk("d2_1234_sa", 32'(sa4), 32'hB); chk("d2_1234_led", 32'(led4), 32'hA4);
    goto(b + 13); chk("d3_1234_sa", 32'(sa4), 32'h7); chk("d3_1234_led", 32'(led4), 32'hF9);

    // Two mid-frame loads: the frame in progress keeps 1234, the later load wins.
    goto(b + 18);
    do_load(16'hABCD, 4'h0, 4'h0);
    step();
    do_load(16'h00EF, 4'h0, 4'h0);
    goto(b + 21); chk("d1_still_1234", 32'(led4), 32'hB0);
    goto(b + 33); chk("d0_00EF", 32'(led4), 32'h8E);
    goto(b + 37); chk("d1_00EF", 32'(led4), 32'h86);
    goto(b + 41); chk("d2_00EF", 32'(led4), 32'hC0);
    goto(b + 45); chk("d3_00EF", 32'(led4), 32'hC0);

    // Load coincident with the boundary edge bypasses straight into the new frame.
    b = next_frame();
    goto(b - 1);
    do_load(16'h5555, 4'h0, 4'h0);
    chk("coincident_ft", 32'(ft4), 32'h1);
    step();
    chk("coincident_sa", 32'(sa4), 32'hE);
    chk("coincident_led", 32'(led4), 32'h92);

    // dp, blank and (optionally) leading-zero suppression together.
    do_load(16'h0050, 4'b0010, 4'b1000);
    b = next_frame();
    goto(b + 1);  chk("mix_d0", 32'(led4), 32'hC0);
    goto(b + 5);  chk("mix_d1", 32'(led4), 32'h12);
    goto(b + 9);
`ifdef LED7SEG_LZS_EN
    chk("mix_d2", 32'(led4), 32'hFF);
`else
    chk("mix_d2", 32'(led4), 32'hC0);
`endif
    goto(b + 13); chk("mix_d3", 32'(led4), 32'hFF);

    // Random loads, including leading zeros and random blanking.
    repeat (400) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0:       mask = 16'hFFFF;
          1:       mask = 16'h0FFF;
          2:       mask = 16'h00FF;
          default: mask = 16'h000F;
        endcase
        digits = 16'($urandom) & mask;
        dp     = 4'($urandom);
        blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        load   = 1'b1;
      end
      step();
      load = 1'b0;
    end

    // Reset in the middle of a scan: outputs drop asynchronously, then dark until a commit.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sa4", 32'(sa4), 32'hF);
    chk("midrst_led4", 32'(led4), 32'hFF);
    chk("midrst_sa1", 32'(sa1), 32'hF);
    chk("midrst_led1", 32'(led1), 32'hFF);
    chk("midrst_ft4", 32'(ft4), 32'h0);
    t = 0;
    load_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_now();
    repeat (40) step();
    do_load(16'h9876, 4'h5, 4'h0);
    repeat (40) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
